trees_pred_packer: RTL and testbench

Downstream stage of the tree-ensemble compute core. It collects one 8-bit class prediction per sample and packs eight predictions into each 64-bit little-endian word. Finished words are buffered in a small first-word-fall-through FIFO and presented as a valid/ready stream to the DMA write channel. Per burst it emits exactly ceil(burst_len/8) words, which matches the DMA write length programmed by the accelerator control FSM.

---
 rtl/trees_pred_packer.sv | 144 ++++++++++++++
 tb/tb_trees_pred_packer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trees_pred_packer.sv
`default_nettype none
// ============================================================================
// Module   : trees_pred_packer
// Brief    : Packs 8-bit class predictions eight-per-word into a FWFT word
//            FIFO and streams ceil(len/8) 64-bit words per burst.
// Revision : 1.0 - initial release
// ============================================================================
module trees_pred_packer #(
    parameter int unsigned N_CLASES   = 32,
    parameter int unsigned MAX_BURST  = 5000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] burst_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_class,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        done,
    output logic        err_class,
    output logic        err_len
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_len;
    logic [31:0] r_cnt;
    logic [63:0] r_partial;
    logic        r_err_class;
    logic        r_err_len;
    logic [64:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic        w_empty;
    logic        w_full;
    logic [2:0]  w_lane;
    logic        w_last_sample;
    logic [63:0] w_word;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_start;
    logic [31:0] w_len_sat;
    logic [64:0] w_head;

    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_lane        = r_cnt[2:0];
    assign w_last_sample = (r_cnt == r_len - 32'd1);
    assign w_word        = r_partial | ({56'd0, in_class} << {w_lane, 3'b000});
    assign w_start       = (r_state == S_IDLE) && start;
    assign w_len_sat     = (burst_len > MAX_BURST) ? MAX_BURST : burst_len;

    // in_ready looks only at registered full, never at out_ready
    assign in_ready      = (r_state == S_PACK) && !w_full;
    assign w_accept      = in_valid && in_ready;
    assign w_push        = w_accept && ((w_lane == 3'd7) || w_last_sample);
    assign w_pop         = out_valid && out_ready;

    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid     = !w_empty;
    assign out_data      = w_empty ? 64'd0 : w_head[63:0];
    assign out_last      = !w_empty && w_head[64];
    assign done          = (r_state == S_DONE);
    assign err_class     = r_err_class;
    assign err_len       = r_err_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (w_len_sat == 32'd0) ? S_DONE : S_PACK;
            S_PACK:  if (w_accept && w_last_sample) w_next = S_DRAIN;
            S_DRAIN: if (w_pop && out_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len       <= 32'd0;
            r_cnt       <= 32'd0;
            r_partial   <= 64'd0;
            r_err_class <= 1'b0;
            r_err_len   <= 1'b0;
        end else if (w_start) begin
            r_len       <= w_len_sat;
            r_cnt       <= 32'd0;
            r_partial   <= 64'd0;
            r_err_class <= 1'b0;
            r_err_len   <= (burst_len > MAX_BURST);
        end else if (w_accept) begin
            r_cnt     <= r_cnt + 32'd1;
            r_partial <= w_push ? 64'd0 : w_word;
            if ({24'd0, in_class} >= N_CLASES) begin
                r_err_class <= 1'b1;
            end
        end
    end

    // w_push already implies !w_full through in_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_last_sample, w_word};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trees_pred_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trees_pred_packer
// Brief    : Scoreboard bench for trees_pred_packer using directed bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trees_pred_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] burst_len = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_class = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last;
    logic        done;
    logic        err_class;
    logic        err_len;

    trees_pred_packer dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done), .err_class(err_class), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          words_seen = 0;
    int          hs_cyc = 0;
    int          acc_cnt = 0;
    logic [63:0] last_data = 64'd0;
    logic [64:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endfunction

    // Monitor: every handshake pops one expected word
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h want none", out_data);
            end else begin
                e = sb.pop_front();
                chk("word_data", out_data, e[63:0]);
                chk("word_last", {63'd0, out_last}, {63'd0, e[64]});
            end
            words_seen++;
            if (out_last) begin
                hs_cyc    = cyc;
                last_data = out_data;
            end
        end
    end

    function automatic logic [7:0] cls_of(input int mode, input int k);
        logic [31:0] kk;
        kk = k;
        case (mode)
            1:       cls_of = kk[7:0] + 8'd5;
            2:       cls_of = (k == 2) ? 8'd40 : kk[7:0];
            default: cls_of = kk[7:0];
        endcase
    endfunction

    function automatic void model_push(input int n, input int mode);
        logic [63:0] w;
        w = 64'd0;
        for (int k = 0; k < n; k++) begin
            w[8*(k%8) +: 8] = cls_of(mode, k);
            if ((k % 8) == 7 || k == n - 1) begin
                sb.push_back({(k == n - 1), w});
                w = 64'd0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int unsigned len, input bit expect_ready);
        burst_len = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        if (expect_ready) chk("in_ready_after_start", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic wait_acc();
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end
        tick();
    endtask

    task automatic drive(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_class = cls_of(mode, k);
            wait_acc();
            acc_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (!done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: got done=0 want 1", nm);
        end else begin
            chk({nm, "_done_cycle"}, cyc, hs_cyc + 1);
            @(negedge clk);
            chk({nm, "_done_width"}, {63'd0, done}, 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_errs", {62'd0, err_class, err_len}, 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // 16 samples, classes 0..15
        out_ready = 1'b1;
        words_seen = 0;
        sb.push_back({1'b0, 64'h0706050403020100});
        sb.push_back({1'b1, 64'h0F0E0D0C0B0A0908});
        do_start(16, 1'b1);
        drive(16, 0);
        wait_done("b16");
        chk("b16_words", words_seen, 2);

        // Out-of-range class on sample 2
        words_seen = 0;
        sb.push_back({1'b1, 64'h0706050403280100});
        do_start(8, 1'b1);
        drive(8, 2);
        wait_done("berr");
        chk("berr_err_class", {63'd0, err_class}, 64'd1);
        chk("berr_words", words_seen, 1);

        // 3 samples 5,6,7; err_class cleared by start
        words_seen = 0;
        sb.push_back({1'b1, 64'h0000000000070605});
        do_start(3, 1'b1);
        chk("b3_err_class_clr", {63'd0, err_class}, 64'd0);
        drive(3, 1);
        wait_done("b3");
        chk("b3_words", words_seen, 1);

        // 80 samples with backpressure until FIFO fills
        out_ready = 1'b0;
        words_seen = 0;
        model_push(80, 0);
        do_start(80, 1'b1);
        acc_cnt = 0;
        fork
            drive(80, 0);
            begin
                int t;
                t = 0;
                while (acc_cnt < 64 && t < 2000) begin
                    tick();
                    t++;
                end
                @(negedge clk);
                chk("b80_in_ready_full", {63'd0, in_ready}, 64'd0);
                chk("b80_out_valid", {63'd0, out_valid}, 64'd1);
                repeat (3) tick();
                chk("b80_accepted_stall", acc_cnt, 64);
                out_ready = 1'b1;
            end
        join
        wait_done("b80");
        chk("b80_words", words_seen, 10);
        chk("b80_sb_empty", sb.size(), 0);

        // Oversized burst saturates to 5000 samples
        words_seen = 0;
        model_push(5000, 0);
        do_start(6000, 1'b1);
        chk("b6000_err_len", {63'd0, err_len}, 64'd1);
        drive(5000, 0);
        wait_done("b6000");
        chk("b6000_words", words_seen, 625);
        chk("b6000_last_full", {56'd0, last_data[63:56]}, 64'h87);

        // Zero-length burst
        words_seen = 0;
        hs_cyc = cyc;
        do_start(0, 1'b0);
        chk("b0_err_len_clr", {63'd0, err_len}, 64'd0);
        wait_done("b0");
        chk("b0_words", words_seen, 0);

        // Reset mid-burst
        out_ready = 1'b0;
        do_start(16, 1'b1);
        drive(10, 0);
        chk("mid_out_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out_data", out_data, 64'd0);
        chk("mid_rst_out_last", {63'd0, out_last}, 64'd0);
        chk("mid_rst_done_errs", {61'd0, done, err_class, err_len}, 64'd0);
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        words_seen = 0;
        sb.push_back({1'b1, 64'h0706050403020100});
        do_start(8, 1'b1);
        drive(8, 0);
        wait_done("post_rst");
        chk("post_rst_words", words_seen, 1);
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
